// File: rtl/spi_master_ctrl.sv
// SPI initiator: frames {cmd,din} MSB first on MOSI, and captures an 8-bit MISO reply for read-data.
// Latency: 12 SS_n-low cycles (20+TURNAROUND for read-data), then GAP; start is dropped while busy.
module spi_master_ctrl #(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned GAP        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAKE,
    ST_SEL,
    ST_SHIFT,
    ST_TURN,
    ST_RECV,
    ST_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [9:0]  frame_q, frame_d;
  logic        is_rd_q, is_rd_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rd_data_d;
  logic        busy_d, done_d, ss_n_d, mosi_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      is_rd_q <= 1'b0;
      rx_q    <= '0;
      rd_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SS_n    <= 1'b1;
      MOSI    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      is_rd_q <= is_rd_d;
      rx_q    <= rx_d;
      rd_data <= rd_data_d;
      busy    <= busy_d;
      done    <= done_d;
      SS_n    <= ss_n_d;
      MOSI    <= mosi_d;
    end
  end

  // Next state and datapath; the outputs below are derived from the next state so they register in step with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    is_rd_d   = is_rd_q;
    rx_d      = rx_q;
    rd_data_d = rd_data;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          frame_d = {cmd, din};
          is_rd_d = (cmd == 2'b11);
          cnt_d   = '0;
          state_d = ST_WAKE;
        end
      end
      ST_WAKE: begin
        state_d = ST_SEL;
      end
      ST_SEL: begin
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == 4'd9) begin
          cnt_d   = '0;
          state_d = is_rd_q ? ST_TURN : ST_GAP;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          frame_d = {frame_q[8:0], 1'b0};
        end
      end
      ST_TURN: begin
        if (cnt_q == 4'(TURNAROUND - 1)) begin
          cnt_d   = '0;
          state_d = ST_RECV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RECV: begin
        rx_d = {rx_q[6:0], MISO};
        if (cnt_q == 4'd7) begin
          rd_data_d = {rx_q[6:0], MISO};
          cnt_d     = '0;
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 4'(GAP - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_GAP) && (state_q != ST_GAP);
    ss_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
    mosi_d = 1'b0;
    if (state_d == ST_SEL || state_d == ST_SHIFT) begin
      mosi_d = frame_d[9];
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed-vector bench for spi_master_ctrl with an expected-frame queue checked by a done-driven monitor.
module tb_spi_master_ctrl;

  localparam int unsigned TA = 2;
  localparam int unsigned GP = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] din = 8'h00;
  logic       busy, done, SS_n, MOSI;
  logic [7:0] rd_data;
  logic       MISO = 1'b1;

  spi_master_ctrl #(.TURNAROUND(TA), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .din(din),
    .busy(busy), .done(done), .rd_data(rd_data),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [11:0] mosi;
    logic [7:0]  rd;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  logic b2b_armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model: 0 = reply slave_byte in the RECV window (1 elsewhere), 1 = MISO tied high.
  int         slave_mode = 0;
  logic [7:0] slave_byte = 8'h00;
  int         low_idx = 0;
  always @(posedge clk) begin
    #1;
    MISO = 1'b1;
    if (SS_n) begin
      low_idx = 0;
    end else begin
      if (slave_mode == 0 && low_idx >= 12 + int'(TA) && low_idx <= 19 + int'(TA))
        MISO = slave_byte[7 - (low_idx - 12 - int'(TA))];
      low_idx++;
    end
  end

  // Monitor: captures each SS_n-low window and scores it when done pulses.
  int          low_len = 0;
  logic [11:0] mosi_bits = '0;
  logic        extra1 = 1'b0;
  logic        in_frame = 1'b0;
  int          high_run = 0;
  logic        gap_track = 1'b0;
  int          gap_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      low_len = 0; mosi_bits = '0; extra1 = 1'b0; in_frame = 1'b0;
      high_run = 0; gap_track = 1'b0; gap_cnt = 0;
    end else begin
      if (!SS_n) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          if (b2b_armed) begin
            check("b2b_ssn_high_cycles", high_run, GP + 1);
            b2b_armed = 1'b0;
          end
        end
        if (low_len < 12) mosi_bits = {mosi_bits[10:0], MOSI};
        else if (MOSI) extra1 = 1'b1;
        low_len++;
        high_run = 0;
      end else begin
        high_run++;
      end
      if (done) begin
        done_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=pulse expected=none at %0t", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("frame_len", low_len, e.len);
          check("frame_mosi", {20'h0, mosi_bits}, {20'h0, e.mosi});
          check("mosi_zero_after_shift", {31'h0, extra1}, 32'h0);
          check("rd_data_at_done", {24'h0, rd_data}, {24'h0, e.rd});
        end
        low_len = 0; mosi_bits = '0; extra1 = 1'b0; in_frame = 1'b0;
        gap_track = 1'b1; gap_cnt = 0;
      end
      if (gap_track) begin
        if (busy) begin
          gap_cnt++;
        end else begin
          check("busy_high_after_ssn_rise", gap_cnt, GP);
          gap_track = 1'b0;
        end
      end
    end
  end

  task automatic wait_done(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 200);
    check({tag, "_done_seen"}, {31'h0, done}, 32'h1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 50);
    check({tag, "_idle"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d,
                      input int elen, input logic [11:0] emosi, input logic [7:0] erd,
                      input string tag);
    exp_t e;
    e.len = elen; e.mosi = emosi; e.rd = erd;
    @(negedge clk);
    q.push_back(e);
    start = 1'b1; cmd = c; din = d;
    @(posedge clk); #1;
    start = 1'b0; cmd = ~c; din = ~d;
    wait_done(tag);
    wait_idle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #23;
    check("rst_ss_n", {31'h0, SS_n}, 32'h1);
    check("rst_mosi", {31'h0, MOSI}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_rd_data", {24'h0, rd_data}, 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write-address 0x5A: WAKE,SEL,SHIFT bits = 0 | 0 | 0,0,0,1,0,1,1,0,1,0
    send(2'b00, 8'h5A, 12, 12'h05A, 8'h00, "wr_addr");

    // Read-data with slave replying 0xC3
    slave_mode = 0; slave_byte = 8'hC3;
    send(2'b11, 8'h00, 22, 12'h700, 8'hC3, "rd_c3");

    // Back-to-back with start held high: 10/07 then 01/FF
    begin
      exp_t e1, e2;
      e1.len = 12; e1.mosi = 12'h607; e1.rd = 8'hC3;
      e2.len = 12; e2.mosi = 12'h1FF; e2.rd = 8'hC3;
      @(negedge clk);
      q.push_back(e1); q.push_back(e2);
      start = 1'b1; cmd = 2'b10; din = 8'h07;
      @(posedge clk); #1;
      cmd = 2'b01; din = 8'hFF;
      wait_done("b2b_first");
      b2b_armed = 1'b1;
      wait_idle("b2b_first");
      @(posedge clk); #1;
      start = 1'b0; cmd = 2'b00; din = 8'h00;
      wait_done("b2b_second");
      wait_idle("b2b_second");
    end

    // Start pulsed mid-frame with a different command is ignored
    begin
      exp_t e;
      e.len = 12; e.mosi = 12'h03C; e.rd = 8'hC3;
      @(negedge clk);
      q.push_back(e);
      start = 1'b1; cmd = 2'b00; din = 8'h3C;
      @(posedge clk); #1; start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; cmd = 2'b11; din = 8'hA5;
      @(negedge clk); start = 1'b0;
      wait_done("ignore");
      wait_idle("ignore");
      repeat (30) @(negedge clk);
      check("ignore_done_count", done_cnt, 5);
      check("ignore_queue_empty", q.size(), 0);
    end

    // Reset at SHIFT bit 5 (din[4]=1 so MOSI is high just before)
    @(negedge clk);
    start = 1'b1; cmd = 2'b01; din = 8'h10;
    @(posedge clk); #1; start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre_rst_mosi_bit5", {31'h0, MOSI}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_ss_n", {31'h0, SS_n}, 32'h1);
    check("mid_rst_mosi", {31'h0, MOSI}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_rd_data", {24'h0, rd_data}, 32'h0);
    @(negedge clk); #1; rst = 1'b0;
    repeat (2) @(negedge clk);
    send(2'b00, 8'hA5, 12, 12'h0A5, 8'h00, "post_rst");

    // MISO tied high: read-data yields 0xFF, which survives a later write
    slave_mode = 1;
    send(2'b11, 8'h00, 22, 12'h700, 8'hFF, "rd_ff");
    send(2'b00, 8'h00, 12, 12'h000, 8'hFF, "wr_after_rd");
    check("rd_data_held", {24'h0, rd_data}, 32'hFF);

    repeat (5) @(negedge clk);
    check("final_done_count", done_cnt, 8);
    check("final_queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
